// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and constants for the period meter.
package misc;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMED     = 2'd1,
      MEASURING = 2'd2
   } capture_state_t;

   localparam int unsigned PERIOD_TIMEOUT_2S = 100_000_000;

endpackage

// File: rtl/period_meter_edge_synchronizer.sv
// rtl/period_meter_edge_synchronizer.sv - 2-flop synchronizer and rising-edge detect.
// Optional 3-sample stability filter under PERIOD_METER_GLITCH_FILTER_EN.
module edge_synchronizer (
   input  logic clock,
   input  logic reset_s2_n,
   input  logic signal_in,
   output logic rise
);

   logic s1_q;
   logic s2_q;

`ifdef PERIOD_METER_GLITCH_FILTER_EN
   logic h1_q;
   logic h2_q;
   logic filt_q;
   logic filt_d;

   // The level only moves once three consecutive s2 samples agree.
   always_comb begin
      filt_d = filt_q;
      if ((s2_q == h1_q) && (h1_q == h2_q)) begin
         filt_d = s2_q;
      end
   end

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         h1_q   <= 1'b0;
         h2_q   <= 1'b0;
         filt_q <= 1'b0;
      end else begin
         s1_q   <= signal_in;
         s2_q   <= s1_q;
         h1_q   <= s2_q;
         h2_q   <= h1_q;
         filt_q <= filt_d;
      end
   end

   assign rise = filt_d & ~filt_q;
`else
   logic prev_q;

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= signal_in;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign rise = s2_q & ~prev_q;
`endif

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures clock cycles between rising edges of signal_in.
// Glitch filtering is enabled by defining PERIOD_METER_GLITCH_FILTER_EN.
module period_meter
   import misc::*;
#(
   parameter int unsigned      WIDTH         = 32,
   parameter logic [WIDTH-1:0] TIMEOUT_COUNT = WIDTH'(PERIOD_TIMEOUT_2S)
) (
   input  logic             clock,
   input  logic             reset_s2_n,
   input  logic             enabled,
   input  logic             signal_in,
   output logic [WIDTH-1:0] period,
   output logic             valid,
   output logic             timeout,
   output logic             present
);

   capture_state_t   state_q;
   logic [WIDTH-1:0] counter_q;
   logic [WIDTH-1:0] period_q;
   logic             valid_q;
   logic             timeout_q;
   logic             present_q;
   logic             rise;

   edge_synchronizer u_edge_synchronizer (
      .clock      (clock),
      .reset_s2_n (reset_s2_n),
      .signal_in  (signal_in),
      .rise       (rise)
   );

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         state_q   <= IDLE;
         counter_q <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         present_q <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         if (!enabled) begin
            state_q   <= IDLE;
            counter_q <= '0;
            present_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q   <= ARMED;
                  counter_q <= '0;
               end
               ARMED: begin
                  if (rise) begin
                     state_q   <= MEASURING;
                     counter_q <= WIDTH'(1);
                  end else begin
                     counter_q <= '0;
                  end
               end
               MEASURING: begin
                  // A rise on the timeout cycle still counts as a valid period.
                  if (rise) begin
                     period_q  <= counter_q;
                     valid_q   <= 1'b1;
                     counter_q <= WIDTH'(1);
                     present_q <= 1'b1;
                  end else if (counter_q == TIMEOUT_COUNT) begin
                     timeout_q <= 1'b1;
                     present_q <= 1'b0;
                     counter_q <= '0;
                     state_q   <= ARMED;
                  end else begin
                     counter_q <= counter_q + WIDTH'(1);
                  end
               end
               default: begin
                  state_q   <= IDLE;
                  counter_q <= '0;
               end
            endcase
         end
      end
   end

   assign period  = period_q;
   assign valid   = valid_q;
   assign timeout = timeout_q;
   assign present = present_q;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter (TIMEOUT_COUNT = 100).
module tb_period_meter;
   import misc::*;

   logic        clock      = 1'b0;
   logic        reset_s2_n = 1'b0;
   logic        enabled    = 1'b0;
   logic        signal_in  = 1'b0;
   logic [31:0] period;
   logic        valid;
   logic        timeout;
   logic        present;

   int          cyc;
   int          valid_cnt;
   int          timeout_cnt;
   int          both_cnt;
   int          first_valid_cyc;
   int          last_valid_cyc;
   int          last_timeout_cyc;
   logic [31:0] last_period;
   int          pass_cnt;
   int          check_cnt;

   always #10 clock = ~clock;

   period_meter #(
      .WIDTH         (32),
      .TIMEOUT_COUNT (32'd100)
   ) dut (
      .clock      (clock),
      .reset_s2_n (reset_s2_n),
      .enabled    (enabled),
      .signal_in  (signal_in),
      .period     (period),
      .valid      (valid),
      .timeout    (timeout),
      .present    (present)
   );

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (valid) begin
         valid_cnt++;
         if (valid_cnt == 1) first_valid_cyc = cyc;
         last_valid_cyc = cyc;
         last_period    = period;
      end
      if (timeout) begin
         timeout_cnt++;
         last_timeout_cyc = cyc;
      end
      if (valid && timeout) both_cnt++;
   endtask

   task automatic drive(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         signal_in = lvl;
         tick();
      end
   endtask

   task automatic clear_stats();
      valid_cnt        = 0;
      timeout_cnt      = 0;
      first_valid_cyc  = -1;
      last_valid_cyc   = -1;
      last_timeout_cyc = -1;
      last_period      = '0;
   endtask

   task automatic restart();
      enabled = 1'b0;
      drive(1'b0, 6);
      enabled = 1'b1;
      drive(1'b0, 3);
      clear_stats();
   endtask

   task automatic test_reset();
      reset_s2_n = 1'b0;
      enabled    = 1'b1;
      drive(1'b0, 3);
      check_cnt++;
      if (period !== 32'd0) $display("FAIL reset_period: got %0d want 0", period); else pass_cnt++;
      check_cnt++;
      if ({valid, timeout, present} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {valid, timeout, present}); else pass_cnt++;
      check_cnt++;
      if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); else pass_cnt++;
      reset_s2_n = 1'b1;
      drive(1'b0, 2);
      check_cnt++;
      if (dut.state_q !== ARMED) $display("FAIL armed_state: got %0d want %0d", dut.state_q, ARMED); else pass_cnt++;
      check_cnt++;
      if ({period, valid, timeout, present} !== 35'd0) $display("FAIL armed_outputs: got period %0d flags %b want 0 000", period, {valid, timeout, present}); else pass_cnt++;
      clear_stats();
   endtask

   task automatic test_square();
      restart();
      for (int p = 0; p < 5; p++) begin
         drive(1'b1, 10);
         drive(1'b0, 10);
      end
      check_cnt++;
      if (valid_cnt !== 4) $display("FAIL square_valid_count: got %0d want 4", valid_cnt); else pass_cnt++;
      check_cnt++;
      if (last_period !== 32'd20) $display("FAIL square_period: got %0d want 20", last_period); else pass_cnt++;
      check_cnt++;
      if ((last_valid_cyc - first_valid_cyc) !== 60) $display("FAIL square_spacing: got %0d want 60", last_valid_cyc - first_valid_cyc); else pass_cnt++;
      check_cnt++;
      if (present !== 1'b1) $display("FAIL square_present: got %b want 1", present); else pass_cnt++;
      check_cnt++;
      if (timeout_cnt !== 0) $display("FAIL square_timeout: got %0d want 0", timeout_cnt); else pass_cnt++;
   endtask

   task automatic test_timeout();
      restart();
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 10);
         drive(1'b0, 10);
      end
      drive(1'b0, 150);
      check_cnt++;
      if (timeout_cnt !== 1) $display("FAIL timeout_count: got %0d want 1", timeout_cnt); else pass_cnt++;
      check_cnt++;
      if ((last_timeout_cyc - last_valid_cyc) !== 100) $display("FAIL timeout_delay: got %0d want 100", last_timeout_cyc - last_valid_cyc); else pass_cnt++;
      check_cnt++;
      if (present !== 1'b0) $display("FAIL timeout_present: got %b want 0", present); else pass_cnt++;
      check_cnt++;
      if (period !== 32'd20) $display("FAIL timeout_period_kept: got %0d want 20", period); else pass_cnt++;
      clear_stats();
      drive(1'b1, 10);
      drive(1'b0, 5);
      check_cnt++;
      if (valid_cnt !== 0) $display("FAIL rearm_first_rise: got %0d valids want 0", valid_cnt); else pass_cnt++;
      drive(1'b0, 5);
      drive(1'b1, 10);
      check_cnt++;
      if (valid_cnt !== 1) $display("FAIL rearm_second_rise: got %0d valids want 1", valid_cnt); else pass_cnt++;
      check_cnt++;
      if (last_period !== 32'd20) $display("FAIL rearm_period: got %0d want 20", last_period); else pass_cnt++;
   endtask

   task automatic test_boundary();
      restart();
      for (int p = 0; p < 2; p++) begin
         drive(1'b1, 10);
         drive(1'b0, 90);
      end
      drive(1'b1, 10);
      drive(1'b0, 10);
      check_cnt++;
      if (timeout_cnt !== 0) $display("FAIL edge100_timeout: got %0d want 0", timeout_cnt); else pass_cnt++;
      check_cnt++;
      if (valid_cnt !== 2) $display("FAIL edge100_valid_count: got %0d want 2", valid_cnt); else pass_cnt++;
      check_cnt++;
      if (last_period !== 32'd100) $display("FAIL edge100_period: got %0d want 100", last_period); else pass_cnt++;
      restart();
      drive(1'b1, 10);
      drive(1'b0, 91);
      drive(1'b1, 10);
      drive(1'b0, 10);
      check_cnt++;
      if ({timeout_cnt, valid_cnt} !== {32'd1, 32'd0}) $display("FAIL edge101: got timeouts %0d valids %0d want 1 0", timeout_cnt, valid_cnt); else pass_cnt++;
   endtask

   task automatic test_enable_drop();
      restart();
      drive(1'b1, 9);
      enabled = 1'b0;
      drive(1'b0, 3);
      drive(1'b1, 3);
      drive(1'b0, 3);
      check_cnt++;
      if (valid_cnt !== 0) $display("FAIL drop_no_valid: got %0d want 0", valid_cnt); else pass_cnt++;
      check_cnt++;
      if (present !== 1'b0) $display("FAIL drop_present: got %b want 0", present); else pass_cnt++;
      enabled = 1'b1;
      drive(1'b0, 5);
      for (int p = 0; p < 2; p++) begin
         drive(1'b1, 15);
         drive(1'b0, 15);
      end
      drive(1'b1, 15);
      drive(1'b0, 5);
      check_cnt++;
      if (valid_cnt !== 2) $display("FAIL drop_valid_count: got %0d want 2", valid_cnt); else pass_cnt++;
      check_cnt++;
      if (last_period !== 32'd30) $display("FAIL drop_period: got %0d want 30", last_period); else pass_cnt++;
   endtask

   task automatic test_glitch();
      restart();
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, 20);
         drive(1'b0, 8);
         drive(1'b1, 2);
         drive(1'b0, 10);
      end
      drive(1'b1, 20);
      drive(1'b0, 5);
`ifdef PERIOD_METER_GLITCH_FILTER_EN
      check_cnt++;
      if (valid_cnt !== 4) $display("FAIL glitch_valid_count: got %0d want 4", valid_cnt); else pass_cnt++;
      check_cnt++;
      if (last_period !== 32'd40) $display("FAIL glitch_period: got %0d want 40", last_period); else pass_cnt++;
`else
      check_cnt++;
      if (valid_cnt !== 8) $display("FAIL glitch_valid_count: got %0d want 8", valid_cnt); else pass_cnt++;
      check_cnt++;
      if (last_period !== 32'd12) $display("FAIL glitch_period: got %0d want 12", last_period); else pass_cnt++;
      restart();
      for (int p = 0; p < 6; p++) begin
         drive(1'b1, 1);
         drive(1'b0, 1);
      end
      drive(1'b0, 4);
      check_cnt++;
      if (valid_cnt !== 5) $display("FAIL min_period_count: got %0d want 5", valid_cnt); else pass_cnt++;
      check_cnt++;
      if (last_period !== 32'd2) $display("FAIL min_period_value: got %0d want 2", last_period); else pass_cnt++;
`endif
   endtask

   task automatic test_exclusive();
      check_cnt++;
      if (both_cnt !== 0) $display("FAIL valid_timeout_overlap: got %0d cycles want 0", both_cnt); else pass_cnt++;
   endtask

   initial begin
      cyc       = 0;
      both_cnt  = 0;
      pass_cnt  = 0;
      check_cnt = 0;
      clear_stats();
      test_reset();
      test_square();
      test_timeout();
      test_boundary();
      test_enable_drop();
      test_glitch();
      test_exclusive();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of an external digital signal in 50 MHz clock cycles.
- Acts as the measuring counterpart to the periodic timers: consumes square waves (e.g. timer-driven blink or external pulse sources) and reports the cycle count between consecutive rising edges.
- Includes an input synchronizer, an edge detector, a measurement counter with timeout, and a registered result with a valid pulse.

Parameters:
- WIDTH, 32: width of counter and period output.
- TIMEOUT_COUNT, 100_000_000: cycles without a rising edge before timeout is declared (2 s at 50 MHz); must be < 2^WIDTH.

Ports:
- clock  input  1  50 MHz system clock.
- reset_s2_n  input  1  asynchronous active-low reset, already synchronized (s2) in the system.
- enabled  input  1  1 = measure; 0 = idle.
- signal_in  input  1  asynchronous external signal to measure.
- period  output  WIDTH  last measured period in clock cycles.
- valid  output  1  one-cycle pulse when period updates.
- timeout  output  1  one-cycle pulse when TIMEOUT_COUNT reached without an edge.
- present  output  1  level; 1 while periodic signal is being tracked.

Behaviour:
- Reset, asynchronous on reset_s2_n low:
  - all state returns to IDLE
  - counter = 0, period = 0, valid = 0, timeout = 0, present = 0
  - synchronizer flops = 0
- Synchronization:
  - signal_in passes through two flops (s1, s2); a third flop holds the previous s2.
  - rise = s2 & !prev.
  - Latency from an input rising edge to rise is 2–3 clock cycles.
- States (capture_state_t):
  - IDLE: entered whenever enabled = 0, regardless of state; counter = 0; valid = timeout = 0; present = 0; period retained. Goes to ARMED when enabled = 1.
  - ARMED: waits for the first rise; counter held at 0. On rise: counter <= 1, go to MEASURING, no valid.
  - MEASURING: counter <= counter + 1 every cycle without rise. On rise: period <= counter, valid = 1 for one cycle, counter <= 1, present <= 1, stay in MEASURING.
- Result: rising edges N cycles apart yield period = N. Minimum measurable period is 2.
- Timeout: in MEASURING with counter == TIMEOUT_COUNT and no rise:
  - timeout = 1 for one cycle, present <= 0, counter <= 0, go to ARMED
  - period retained
- Boundary rules:
  - rise and counter == TIMEOUT_COUNT in the same cycle: rise wins; period = TIMEOUT_COUNT, valid = 1, timeout = 0.
  - valid and timeout are never asserted in the same cycle.
  - enabled dropping mid-measurement: the partial count is discarded and no valid is issued.
  - reset mid-measurement: immediate clear, including period.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: PERIOD_METER_GLITCH_FILTER_EN.
- When defined:
  - the synchronized signal feeds a 3-sample stability filter
  - the filtered level changes only after 3 consecutive equal s2 samples
  - pulses or gaps shorter than 3 cycles are ignored
  - edge latency increases by 2 cycles; the measured period of a clean signal is unchanged
- When undefined: rise is derived directly from s2 and prev.

Decomposition:
- Package misc:
  - capture_state_t enum {IDLE, ARMED, MEASURING}
  - constant PERIOD_TIMEOUT_2S = 100_000_000
- Sub-module edge_synchronizer:
  - contains the 2-flop synchronizer, optional filter and rise detection
  - ports: clock, reset_s2_n, signal_in, rise
  - reused later by other input blocks

Test Plan (TIMEOUT_COUNT = 100 for benches):
- Reset held, then released with enabled = 1 and signal_in = 0 -> period = 0, valid = 0, timeout = 0, present = 0; state ARMED.
- Square wave with period 20 cycles (10 high / 10 low) -> first valid on the second rising edge with period = 20, then valid every 20 cycles; present = 1.
- Square wave stops after 3 periods -> timeout pulses exactly 100 cycles after the last counted rise; present = 0; period stays 20; next rise gives no valid, the following rise does.
- Rising edges exactly 100 cycles apart -> valid with period = 100, no timeout.
- enabled dropped 7 cycles into a measurement, raised again, then edges 30 cycles apart -> no valid during the drop; first valid period = 30.
- With PERIOD_METER_GLITCH_FILTER_EN: 2-cycle high glitches inside a 40-cycle square wave -> period = 40, no extra valid. Without the macro, the same stimulus gives shorter periods.
